buzzer_melody_seq: RTL

Sequencer that drives the shared `pwm` datapath of the buzzer path with a fixed eight-note scale (C4..C5). It steps through a note ROM, loads the PWM phase-step (`period`) and `duty` for each note, and holds each note for a programmable time followed by a silent gap. It sits between the debounced key events and the `pwm` instance, replacing the one-shot beep control in the buzzer top level.

---
 rtl/buzzer_melody_seq_if.sv | 21 ++
 rtl/buzzer_melody_seq.sv | 98 +++++++++
 2 files changed

// File: rtl/buzzer_melody_seq_if.sv
// buzzer_melody_seq_if: control inputs and PWM/status outputs of the melody sequencer.
interface buzzer_melody_seq_if;
    logic        start;
    logic        stop;
    logic        loop;
    logic [1:0]  volume;
    logic [31:0] period;
    logic [31:0] duty;
    logic        buzzer_en;
    logic        busy;
    logic [2:0]  note_idx;
    logic        done;
    modport master (
        output start, stop, loop, volume,
        input  period, duty, buzzer_en, busy, note_idx, done
    );
    modport slave (
        input  start, stop, loop, volume,
        output period, duty, buzzer_en, busy, note_idx, done
    );
endinterface

// File: rtl/buzzer_melody_seq.sv
// buzzer_melody_seq: plays the C4..C5 scale through the pwm datapath, one note then one gap per step.
module buzzer_melody_seq #(
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000
) (
    input logic clk,
    input logic rst_n,
    buzzer_melody_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    // phase steps for f * 2^32 / 50 MHz
    localparam logic [31:0] ROM [8] = '{32'd22506, 32'd25254, 32'd28347, 32'd29979,
                                        32'd33673, 32'd37796, 32'd42434, 32'd44925};
    state_t      state, state_d;
    logic [31:0] timer, timer_d;
    logic [2:0]  idx_d;
    logic        loop_q, loop_d;
    logic [31:0] duty_d, period_d;
    logic        buzzer_en_d, busy_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            loop_q        <= 1'b0;
            bus.note_idx  <= '0;
            bus.duty      <= 32'h2000_0000;
            bus.period    <= '0;
            bus.buzzer_en <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            loop_q        <= loop_d;
            bus.note_idx  <= idx_d;
            bus.duty      <= duty_d;
            bus.period    <= period_d;
            bus.buzzer_en <= buzzer_en_d;
            bus.busy      <= busy_d;
            bus.done      <= done_d;
        end
    end

    // stop outranks start and every timer expiry
    always_comb begin
        state_d = state;
        timer_d = timer + 32'd1;
        idx_d   = bus.note_idx;
        loop_d  = loop_q;
        duty_d  = bus.duty;
        done_d  = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    timer_d = '0;
                    if (bus.start) begin
                        state_d = PLAY;
                        idx_d   = '0;
                        loop_d  = bus.loop;
                        duty_d  = {{1'b0, bus.volume} + 3'd1, 29'd0};
                    end
                end
                PLAY: begin
                    if (timer == NOTE_CYCLES - 1) begin
                        state_d = GAP;
                        timer_d = '0;
                    end
                end
                GAP: begin
                    if (timer == GAP_CYCLES - 1) begin
                        timer_d = '0;
                        if (bus.note_idx != 3'd7 || loop_q) begin
                            state_d = PLAY;
                            idx_d   = bus.note_idx + 3'd1;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        period_d    = state_d == PLAY ? ROM[idx_d] : 32'd0;
        buzzer_en_d = state_d == PLAY;
        busy_d      = state_d != IDLE;
    end
endmodule
